// File: rtl/spi_burst_sequencer_if.sv
// Sequencer bus bundle: conditioned SPI strobes and shift-register data in,
// memory request/grant handshake and latch/buffer/memory controls out.
interface spi_burst_sequencer_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              cs_n;
  logic              sclk_pos;
  logic              sclk_neg;
  logic [DATA_W-1:0] sr_pdata;
  logic              mem_grant;
  logic              mem_req;
  logic              ad_we;
  logic              sr_load;
  logic              dm_we;
  logic              miso_en;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              err;

  // master: SPI front end / memory arbiter side; slave: the sequencer
  modport master (
    output cs_n, sclk_pos, sclk_neg, sr_pdata, mem_grant,
    input  mem_req, ad_we, sr_load, dm_we, miso_en, addr, busy, err
  );

  modport slave (
    input  cs_n, sclk_pos, sclk_neg, sr_pdata, mem_grant,
    output mem_req, ad_we, sr_load, dm_we, miso_en, addr, busy, err
  );
endinterface

// File: rtl/spi_burst_sequencer.sv
// SPI slave memory-path transaction sequencer: address decode, memory request/grant, MISO enable.
// SPI_SEQ_BURST_EN defined: auto-increment bursts; undefined: one data byte per CS window.
module spi_burst_sequencer #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  spi_burst_sequencer_if.slave bus
);

`ifdef SPI_SEQ_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    DECODE   = 3'd2,
    RD_REQ   = 3'd3,
    RD_SHIFT = 3'd4,
    WR_SHIFT = 3'd5,
    WR_REQ   = 3'd6,
    HOLD     = 3'd7
  } state_e;

  state_e            state_q;
  state_e            state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic              err_q;
  logic              err_nxt;
  logic              miso_en_q;
  logic              miso_en_nxt;
  logic              busy_q;
  logic              ad_we_q;
  logic              mem_req_q;
  logic              sr_load_c;
  logic              dm_we_c;
  logic              counting;
  logic              byte_done;
  logic              in_req;
  logic              overrun;

  assign counting  = (state_q == GET_ADDR) || (state_q == RD_SHIFT) || (state_q == WR_SHIFT);
  assign byte_done = counting && bus.sclk_pos && (cnt_q == LAST_BIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: chip-select release overrides everything, then overrun beats grant
  always_comb begin
    state_nxt = state_q;
    if ((state_q != IDLE) && bus.cs_n) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (!bus.cs_n) state_nxt = GET_ADDR;
        GET_ADDR: if (byte_done) state_nxt = DECODE;
        DECODE:   state_nxt = bus.sr_pdata[0] ? RD_REQ : WR_SHIFT;
        RD_REQ: begin
          if (bus.sclk_pos)       state_nxt = HOLD;
          else if (bus.mem_grant) state_nxt = RD_SHIFT;
        end
        RD_SHIFT: if (byte_done) state_nxt = BURST ? RD_REQ : HOLD;
        WR_SHIFT: if (byte_done) state_nxt = WR_REQ;
        WR_REQ: begin
          if (bus.sclk_pos)       state_nxt = HOLD;
          else if (bus.mem_grant) state_nxt = BURST ? WR_SHIFT : HOLD;
        end
        HOLD:     state_nxt = HOLD;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: grant-qualified strobes plus next values of the registered controls
  always_comb begin
    in_req      = (state_q == RD_REQ) || (state_q == WR_REQ);
    overrun     = in_req && !bus.cs_n && bus.sclk_pos;
    sr_load_c   = (state_q == RD_REQ) && (state_nxt == RD_SHIFT);
    dm_we_c     = (state_q == WR_REQ) && !bus.cs_n && !bus.sclk_pos && bus.mem_grant;
    addr_nxt    = addr_q;
    err_nxt     = err_q;
    miso_en_nxt = miso_en_q;

    if ((state_q == DECODE) && (state_nxt != IDLE)) begin
      addr_nxt = bus.sr_pdata[ADDR_W:1];
    end else if (BURST && (((state_q == RD_SHIFT) && (state_nxt == RD_REQ)) ||
                           ((state_q == WR_REQ) && (state_nxt == WR_SHIFT)))) begin
      addr_nxt = addr_q + ADDR_W'(1);
    end

    if ((state_q == IDLE) && (state_nxt == GET_ADDR)) begin
      err_nxt = 1'b0;
    end else if (overrun) begin
      err_nxt = 1'b1;
    end

    // Once parked in HOLD, let the last driven bit finish its SCLK phase before release
    if (state_nxt == IDLE) begin
      miso_en_nxt = 1'b0;
    end else if (sr_load_c) begin
      miso_en_nxt = 1'b1;
    end else if ((state_q == HOLD) && bus.sclk_neg) begin
      miso_en_nxt = 1'b0;
    end
  end

  // Bit counter and registered controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      miso_en_q <= 1'b0;
      busy_q    <= 1'b0;
      ad_we_q   <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      if (state_nxt != state_q) begin
        cnt_q <= '0;
      end else if (counting && bus.sclk_pos) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      addr_q    <= addr_nxt;
      err_q     <= err_nxt;
      miso_en_q <= miso_en_nxt;
      busy_q    <= (state_nxt != IDLE);
      ad_we_q   <= (state_nxt == DECODE);
      mem_req_q <= (state_nxt == RD_REQ) || (state_nxt == WR_REQ);
    end
  end

  assign bus.mem_req = mem_req_q;
  assign bus.ad_we   = ad_we_q;
  assign bus.sr_load = sr_load_c;
  assign bus.dm_we   = dm_we_c;
  assign bus.miso_en = miso_en_q;
  assign bus.addr    = addr_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;

endmodule

// File: doc/spi_burst_sequencer.md
Name: spi_burst_sequencer

Overview:
Transaction controller for the SPI slave memory path. It counts conditioned SCLK edges and decodes the address/R-W byte. It sequences the address latch, the shift-register parallel load, data-memory writes and the MISO tri-state enable. Data-memory access goes through a request/grant handshake, so the memory can be shared with another master. Sits between the input conditioners / shift register and the address latch / data memory / MISO buffer.

Parameters:
ADDR_W, 7, memory address width; the address byte carries it in bits [7:1].
DATA_W, 8, shift-register/memory word width; the bit counter wraps at DATA_W.

Ports:
clk  input  1  system (FPGA) clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
cs_n  input  1  conditioned chip select, active low
sclk_pos  input  1  one-clk pulse on SCLK rising edge (conditioned)
sclk_neg  input  1  one-clk pulse on SCLK falling edge (conditioned)
sr_pdata  input  DATA_W  shift-register parallel output
mem_grant  input  1  memory arbiter grant, valid only while mem_req=1
mem_req  output  1  request for one data-memory access
ad_we  output  1  address-latch write enable, 1-clk pulse
sr_load  output  1  shift-register parallel-load enable, 1-clk pulse
dm_we  output  1  data-memory write enable, 1-clk pulse
miso_en  output  1  MISO tri-state enable
addr  output  ADDR_W  current memory address
busy  output  1  state != IDLE
err  output  1  sticky overrun flag

Behaviour:
- Reset (rst_n=0, async): state=IDLE, bit counter=0, addr=0. All outputs 0: mem_req, ad_we, sr_load, dm_we, miso_en, busy, err.
- Shift register updates on the clk where sclk_pos=1; sr_pdata is valid from the following clk. All decode uses it then.
- Bit counter: 3-bit, increments on sclk_pos in GET_ADDR/RD_SHIFT/WR_SHIFT, clears on each state entry. "Byte done" = 8th sclk_pos.
- States:
  - IDLE: cs_n=0 -> GET_ADDR; err cleared on this transition.
  - GET_ADDR: byte done -> DECODE.
  - DECODE (1 clk): ad_we=1; addr <= sr_pdata[7:1]; sr_pdata[0]=1 -> RD_REQ, else WR_SHIFT.
  - RD_REQ: mem_req=1. In the clk mem_grant=1: sr_load=1, miso_en set, -> RD_SHIFT. mem_req drops the next clk.
  - RD_SHIFT: miso_en=1; byte done -> addr+1, -> RD_REQ.
  - WR_SHIFT: byte done -> WR_REQ.
  - WR_REQ: mem_req=1. In the grant clk: dm_we=1 (addr is the pre-increment value), then addr+1 -> WR_SHIFT.
  - HOLD: all enables 0; wait for cs_n=1.
- miso_en stays 1 from the first read load until the transaction ends; it is never 1 in write transactions.
- Address arithmetic: modulo 2^ADDR_W; 127+1 -> 0, no error.
- Overrun: sclk_pos while in RD_REQ or WR_REQ -> err=1, mem_req=0 next clk, -> HOLD. No dm_we/sr_load is issued for that byte.
- cs_n=1 in any non-IDLE state -> IDLE next clk. mem_req, miso_en and busy go 0; counter cleared; a partial byte is discarded.
- cs_n=1 in the same clk as mem_grant: cs wins, no dm_we/sr_load pulse.
- sclk_neg is used only to time-align miso_en release.
- Simultaneous sclk_pos and byte-done decode cannot occur (DECODE is 1 clk).

Optional Feature:
SPI_SEQ_BURST_EN
- Defined: auto-increment burst as above; unlimited bytes per CS window.
- Undefined: single-access. After the first data byte (read shifted out, or write dm_we issued) -> HOLD until cs_n=1. addr is not incremented; further SCLK edges are ignored and do not set err.

Test Plan:
- Reset mid-read (rst_n low during RD_SHIFT) -> all outputs 0 immediately, state IDLE, addr=0.
- Write: cs_n=0, byte 0x14 (addr 0x0A, W), byte 0x5A, grant 2 clks after request -> ad_we pulse after the 8th edge, addr=0x0A; exactly one dm_we pulse, addr=0x0A at the pulse; miso_en never 1.
- Read burst (BURST_EN): byte 0xFF (addr 0x7F, R), 16 data edges, immediate grants -> sr_load pulses with addr 0x7F then 0x00 (wrap); miso_en=1 until cs_n=1; err=0.
- Overrun: write transaction, grant withheld, 9th sclk_pos after the data byte -> err=1, mem_req=0, no dm_we. Next cs_n fall clears err.
- Abort: cs_n=1 after 5 data bits of a write -> IDLE next clk, no dm_we, busy=0.
- Single mode (macro undefined): read at 0x03, 16 data edges -> one sr_load only, addr stays 0x03, err=0.
